// File: rtl/gfx_pkg.sv
// Shared graphics definitions: fill-pattern codes, fill FSM encoding and the
// default 160x120 screen geometry used by the drawing engines.
package gfx_pkg;

    localparam int GFX_SCREEN_W = 160;
    localparam int GFX_SCREEN_H = 120;

    localparam logic [1:0] FILL_SOLID   = 2'd0;
    localparam logic [1:0] FILL_VSTRIPE = 2'd1;
    localparam logic [1:0] FILL_HSTRIPE = 2'd2;
    localparam logic [1:0] FILL_CHECKER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/fill_pattern_gen.sv
// Combinational pixel colour for a fill pattern, derived only from the pixel's
// own coordinates so other engines can reuse it for patterned strokes.
module fill_pattern_gen
    import gfx_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
) (
    input  logic [1:0]         mode,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [COLOR_W-1:0] color_in,
    output logic [COLOR_W-1:0] color
);

    always_comb begin
        color = color_in;
        case (mode)
            FILL_SOLID:   color = color_in;
            FILL_VSTRIPE: color = COLOR_W'(x);
            FILL_HSTRIPE: color = COLOR_W'(y);
            FILL_CHECKER: color = (x[0] ^ y[0]) ? ~color_in : color_in;
            default:      color = color_in;
        endcase
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: orders and clips a corner pair to the screen, then
// streams one patterned pixel per cycle in raster order to the pixel-write port.
module rect_fill_engine
    import gfx_pkg::*;
#(
    parameter int SCREEN_W = GFX_SCREEN_W,
    parameter int SCREEN_H = GFX_SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] color_in,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [X_W:0]   X_LIM  = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W + 1)'(SCREEN_H);

    fill_state_e        state_q, state_d;
    // Corner registers hold the raw request in SETUP and the ordered, clipped
    // bounds (a = low corner, b = high corner) during FILL.
    logic [X_W-1:0]     ax_q, ax_d, bx_q, bx_d;
    logic [Y_W-1:0]     ay_q, ay_d, by_q, by_d;
    logic [1:0]         mode_q, mode_d;
    logic [COLOR_W-1:0] cin_q, cin_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [X_W-1:0]     xl, xh_raw, xh;
    logic [Y_W-1:0]     yl, yh_raw, yh;
    logic               empty;
    logic [COLOR_W-1:0] pat_color;

    always_comb begin
        xl     = (ax_q < bx_q) ? ax_q : bx_q;
        xh_raw = (ax_q < bx_q) ? bx_q : ax_q;
        yl     = (ay_q < by_q) ? ay_q : by_q;
        yh_raw = (ay_q < by_q) ? by_q : ay_q;
        xh     = (xh_raw > X_LAST) ? X_LAST : xh_raw;
        yh     = (yh_raw > Y_LAST) ? Y_LAST : yh_raw;
        empty  = ({1'b0, xl} >= X_LIM) || ({1'b0, yl} >= Y_LIM);
    end

    // Colour is evaluated on the next coordinates so it registers alongside them.
    fill_pattern_gen #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COLOR_W (COLOR_W)
    ) u_pattern (
        .mode     (mode_q),
        .x        (x_d),
        .y        (y_d),
        .color_in (cin_q),
        .color    (pat_color)
    );

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        bx_d    = bx_q;
        ay_d    = ay_q;
        by_d    = by_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        x_d     = x_q;
        y_d     = y_q;
        plot_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ax_d    = x0;
                    bx_d    = x1;
                    ay_d    = y0;
                    by_d    = y1;
                    mode_d  = mode;
                    cin_d   = color_in;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (empty) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ax_d    = xl;
                    bx_d    = xh;
                    ay_d    = yl;
                    by_d    = yh;
                    x_d     = xl;
                    y_d     = yl;
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if ((x_q == bx_q) && (y_q == by_q)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    if (x_q == bx_q) begin
                        x_d = ax_q;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                    plot_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        color_d = plot_d ? pat_color : color_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ax_q    <= '0;
            bx_q    <= '0;
            ay_q    <= '0;
            by_q    <= '0;
            mode_q  <= '0;
            cin_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            bx_q    <= bx_d;
            ay_q    <= ay_d;
            by_q    <= by_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
